// File: rtl/sd_lese_arbiter_pkg.sv
// Shared constants and state encoding for the SD sector-read path.
// Any block that talks to the SD card reader uses these timeouts and widths.
package sd_lese_arbiter_pkg;

    localparam int START_TIMEOUT_DEF = 1024;
    localparam int LESE_TIMEOUT_DEF  = 16777215;
    localparam int CNT_W             = 24;
    localparam int ADDR_W            = 32;
    localparam int DATA_W            = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WARTEN = 2'd2,
        ST_FERTIG = 2'd3
    } sd_zustand_e;

endpackage

// File: rtl/sd_rr_waehler.sv
// Two-way round-robin selector.
// zeiger_i is the requester granted last; on a tie the other one wins.
module sd_rr_waehler (
    input  logic [1:0] anfrage_i,
    input  logic       zeiger_i,
    output logic       gueltig_o,
    output logic       index_o
);

    // pick the winning requester index
    always_comb begin
        gueltig_o = |anfrage_i;
        index_o   = 1'b0;
        case (anfrage_i)
            2'b01:   index_o = 1'b0;
            2'b10:   index_o = 1'b1;
            2'b11:   index_o = ~zeiger_i;
            default: index_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sd_lese_arbiter.sv
// Arbitrates two sector-read requesters onto one SD card reader.
// Data is not buffered: Daten is SdDaten, valid in the Fertig cycle.
module sd_lese_arbiter
    import sd_lese_arbiter_pkg::*;
#(
    parameter int START_TIMEOUT = START_TIMEOUT_DEF,
    parameter int LESE_TIMEOUT  = LESE_TIMEOUT_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Anfrage0,
    input  logic              Anfrage1,
    input  logic [ADDR_W-1:0] Adresse0,
    input  logic [ADDR_W-1:0] Adresse1,
    output logic              Fertig0,
    output logic              Fertig1,
    output logic              Fehler,
    output logic [DATA_W-1:0] Daten,
    output logic              Busy,
    output logic [ADDR_W-1:0] SdAdresse,
    output logic              SdLesen,
    input  logic              SdBusy,
    input  logic              SdFertig,
    input  logic [DATA_W-1:0] SdDaten
);

    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT);
    localparam logic [CNT_W-1:0] LESE_LIM  = CNT_W'(LESE_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    sd_zustand_e       state_q, state_d;
    logic              idx_q, idx_d;
    logic              ptr_q, ptr_d;
    logic              flag_q, flag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lesen_q, fertig0_q, fertig1_q, fehler_q, busy_q;
    logic              gnt_valid_s, gnt_idx_s;

    sd_rr_waehler u_waehler (
        .anfrage_i ({Anfrage1, Anfrage0}),
        .zeiger_i  (ptr_q),
        .gueltig_o (gnt_valid_s),
        .index_o   (gnt_idx_s)
    );

    // next-state, grant latching and timeout detection
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        flag_d  = flag_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                // a reader still busy from an aborted or timed-out read blocks new grants
                if (gnt_valid_s && !SdBusy) begin
                    state_d = ST_START;
                    idx_d   = gnt_idx_s;
                    ptr_d   = gnt_idx_s;
                    addr_d  = gnt_idx_s ? Adresse1 : Adresse0;
                    flag_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (SdBusy) begin
                    state_d = ST_WARTEN;
                end else if (cnt_q >= START_LIM) begin
                    state_d = ST_FERTIG;
                    flag_d  = 1'b1;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_WARTEN: begin
                if (SdFertig) begin
                    state_d = ST_FERTIG;
                end else if (cnt_q >= LESE_LIM) begin
                    state_d = ST_FERTIG;
                    flag_d  = 1'b1;
                end else begin
                    state_d = ST_WARTEN;
                end
            end
            ST_FERTIG: begin
                state_d = ST_IDLE;
                flag_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                flag_d  = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // state registers; outputs registered from the next state so they align with it
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= 1'b0;
            ptr_q     <= 1'b1;
            flag_q    <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            lesen_q   <= 1'b0;
            fertig0_q <= 1'b0;
            fertig1_q <= 1'b0;
            fehler_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            flag_q    <= flag_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            lesen_q   <= (state_d == ST_START);
            fertig0_q <= (state_d == ST_FERTIG) && !idx_d;
            fertig1_q <= (state_d == ST_FERTIG) && idx_d;
            fehler_q  <= (state_d == ST_FERTIG) && flag_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign Fertig0   = fertig0_q;
    assign Fertig1   = fertig1_q;
    assign Fehler    = fehler_q;
    assign Busy      = busy_q;
    assign SdLesen   = lesen_q;
    assign SdAdresse = addr_q;
    assign Daten     = SdDaten;

endmodule
